// File: rtl/fproc_pkg.sv
// Shared types and defaults for the fproc measurement stage.
// FPROC_TIMEOUT_EN (optional) enables the bounded WAIT in fproc_meas.
package fproc_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int ID_WIDTH_DEF       = 8;
  localparam int N_MEAS_DEF         = 8;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fproc_state_e;

  // Fill bits for the special response words; replicated to DATA_WIDTH at use.
  localparam logic FPROC_DATA_BADID   = 1'b0;
  localparam logic FPROC_DATA_TIMEOUT = 1'b1;

endpackage

// File: rtl/meas_latch_bank.sv
// Per-channel fresh/bit latches for measurement results, with a consume port
// (response taken) and a load-block port (result bypassed straight to the core).
module meas_latch_bank #(
  parameter int N_MEAS = 8,
  localparam int IDX_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_MEAS-1:0] meas_valid_i,
  input  logic [N_MEAS-1:0] meas_bit_i,
  input  logic              consume_en_i,
  input  logic [IDX_W-1:0]  consume_idx_i,
  input  logic              block_en_i,
  input  logic [IDX_W-1:0]  block_idx_i,
  output logic [N_MEAS-1:0] fresh_o,
  output logic [N_MEAS-1:0] bits_o,
  output logic              overrun_o
);

  logic [N_MEAS-1:0] fresh_q;
  logic [N_MEAS-1:0] bit_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_MEAS; gi++) begin : g_chan
      logic load;
      logic consume;
      assign load    = meas_valid_i[gi] && !(block_en_i && (block_idx_i == IDX_W'(gi)));
      assign consume = consume_en_i && (consume_idx_i == IDX_W'(gi));

      // A load in the same cycle as a consume keeps the channel fresh.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          fresh_q[gi] <= 1'b0;
          bit_q[gi]   <= 1'b0;
        end else if (load) begin
          fresh_q[gi] <= 1'b1;
          bit_q[gi]   <= meas_bit_i[gi];
        end else if (consume) begin
          fresh_q[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign fresh_o   = fresh_q;
  assign bits_o    = bit_q;
  assign overrun_o = |(meas_valid_i & fresh_q);

endmodule

// File: rtl/fproc_meas.sv
// Answers core fproc requests with the latest measurement bit of a channel,
// stalling fproc_ready until a result is available. FPROC_TIMEOUT_EN bounds the wait.
module fproc_meas
  import fproc_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int ID_WIDTH       = ID_WIDTH_DEF,
  parameter int N_MEAS         = N_MEAS_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   fproc_id,
  input  logic                  fproc_en,
  input  logic [N_MEAS-1:0]     meas_valid,
  input  logic [N_MEAS-1:0]     meas_bit,
  output logic                  fproc_ready,
  output logic [DATA_WIDTH-1:0] fproc_data,
  output logic                  busy,
  output logic                  err_bad_id,
  output logic                  err_overrun,
  output logic                  timeout
);

  localparam int IDX_W = (N_MEAS > 1) ? $clog2(N_MEAS) : 1;

  fproc_state_e          state_q;
  logic [IDX_W-1:0]      id_q;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  bad_id_q;
  logic                  overrun_q;

  logic [N_MEAS-1:0] fresh;
  logic [N_MEAS-1:0] bits;
  logic              bank_overrun;

  logic [IDX_W-1:0] req_idx;
  logic             id_ok;
  logic             idle_req;
  logic             wait_hit;
  logic             consume_en;
  logic             idle_bypass;
  logic             block_en;
  logic [IDX_W-1:0] block_idx;

  assign req_idx     = fproc_id[IDX_W-1:0];
  assign id_ok       = (fproc_id < ID_WIDTH'(N_MEAS));
  assign idle_req    = (state_q == IDLE) && fproc_en;
  assign wait_hit    = (state_q == WAIT) && meas_valid[id_q];
  assign consume_en  = idle_req && id_ok && fresh[req_idx];
  assign idle_bypass = idle_req && id_ok && !fresh[req_idx] && meas_valid[req_idx];
  // Bypassed results go straight to the core and must not leave the channel fresh.
  assign block_en    = idle_bypass || wait_hit;
  assign block_idx   = idle_bypass ? req_idx : id_q;

  meas_latch_bank #(
    .N_MEAS(N_MEAS)
  ) u_bank (
    .clk          (clk),
    .reset        (reset),
    .meas_valid_i (meas_valid),
    .meas_bit_i   (meas_bit),
    .consume_en_i (consume_en),
    .consume_idx_i(req_idx),
    .block_en_i   (block_en),
    .block_idx_i  (block_idx),
    .fresh_o      (fresh),
    .bits_o       (bits),
    .overrun_o    (bank_overrun)
  );

`ifdef FPROC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      id_q      <= '0;
      ready_q   <= 1'b0;
      data_q    <= '0;
      bad_id_q  <= 1'b0;
      overrun_q <= 1'b0;
`ifdef FPROC_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      ready_q <= 1'b0;
      if ((fproc_en && (state_q != IDLE)) || bank_overrun) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (fproc_en) begin
            id_q <= req_idx;
`ifdef FPROC_TIMEOUT_EN
            cnt_q <= '0;
`endif
            if (!id_ok) begin
              bad_id_q <= 1'b1;
              data_q   <= {DATA_WIDTH{FPROC_DATA_BADID}};
              ready_q  <= 1'b1;
              state_q  <= RESP;
            end else if (fresh[req_idx]) begin
              data_q  <= {{(DATA_WIDTH-1){1'b0}}, bits[req_idx]};
              ready_q <= 1'b1;
              state_q <= RESP;
            end else if (meas_valid[req_idx]) begin
              data_q  <= {{(DATA_WIDTH-1){1'b0}}, meas_bit[req_idx]};
              ready_q <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (meas_valid[id_q]) begin
            data_q  <= {{(DATA_WIDTH-1){1'b0}}, meas_bit[id_q]};
            ready_q <= 1'b1;
            state_q <= RESP;
`ifdef FPROC_TIMEOUT_EN
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            data_q    <= {DATA_WIDTH{FPROC_DATA_TIMEOUT}};
            timeout_q <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`endif
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fproc_ready = ready_q;
  assign fproc_data  = data_q;
  assign busy        = (state_q != IDLE);
  assign err_bad_id  = bad_id_q;
  assign err_overrun = overrun_q;

`ifdef FPROC_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/fproc_meas.md
Name: fproc_meas

Overview:
- Function-processor stage that answers the core's fproc requests (fproc_id / fproc_en) with a qubit measurement result (fproc_ready / fproc_data).
- Latches single-bit measurement results per readout channel from the demod/discriminator and hands them to the core.
- Blocks the core, via a delayed fproc_ready, until the requested channel has a fresh result.

Parameters:
- DATA_WIDTH, 32, width of fproc_data (matches core datapath)
- ID_WIDTH, 8, width of fproc_id (matches core SYNC_BARRIER_WIDTH)
- N_MEAS, 8, number of measurement channels; legal ids 0..N_MEAS-1
- TIMEOUT_CYCLES, 1024, wait limit; used only with FPROC_TIMEOUT_EN

Ports:
- clk, in, 1, clock
- reset, in, 1, asynchronous active-low reset
- fproc_id, in, ID_WIDTH, requested channel; sampled when fproc_en=1
- fproc_en, in, 1, one-cycle request strobe from core
- meas_valid, in, N_MEAS, per-channel one-cycle result strobe
- meas_bit, in, N_MEAS, per-channel result; valid with meas_valid
- fproc_ready, out, 1, one-cycle response strobe to core
- fproc_data, out, DATA_WIDTH, response data; valid when fproc_ready=1
- busy, out, 1, request outstanding
- err_bad_id, out, 1, sticky: request with id >= N_MEAS
- err_overrun, out, 1, sticky: fproc_en while busy, or meas_valid on a channel already fresh
- timeout, out, 1, sticky; tied 0 without FPROC_TIMEOUT_EN

Behaviour:
- Reset (reset=0, async):
  - All outputs 0, fproc_data 0.
  - Every channel's fresh flag and stored bit cleared.
  - FSM enters IDLE.
- Per-channel latch:
  - meas_valid[i]=1 loads meas_bit[i] and sets fresh[i].
  - Consumption by a response clears fresh[i].
  - Load and consume on the same channel in the same cycle: the load wins and fresh stays set.
- FSM states: IDLE, WAIT, RESP.
- IDLE, on fproc_en=1, latch id:
  - id >= N_MEAS: go to RESP with data 0; set err_bad_id.
  - fresh[id]=1: go to RESP with the stored bit; clear fresh[id].
  - meas_valid[id]=1 in the same cycle: go to RESP with meas_bit[id] (bypass); fresh[id] stays clear.
  - Otherwise: go to WAIT.
- WAIT: on meas_valid[id]=1, go to RESP with meas_bit[id] (bypass; fresh not set).
- RESP:
  - fproc_ready=1 for exactly one cycle, fproc_data = {(DATA_WIDTH-1)'0, bit}.
  - Next state IDLE.
- Latency:
  - Request to fproc_ready is exactly 1 cycle when data is available (fresh or bypass).
  - Otherwise it is 1 cycle after the matching meas_valid.
- busy = 1 in WAIT and RESP.
- fproc_en in WAIT or RESP is ignored and sets err_overrun. The core issues one request at a time.
- fproc_data holds its last value between responses.
- Other channels keep latching while the FSM waits.
- Reset mid-WAIT abandons the request; no fproc_ready is generated.
- Sticky errors clear only on reset.

Optional Feature:
- Macro: FPROC_TIMEOUT_EN.
- Defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) runs in WAIT, starting at 0 on entry.
  - When the count reaches TIMEOUT_CYCLES with no meas_valid[id], go to RESP with fproc_data = all ones and set timeout.
  - meas_valid on the terminal cycle takes priority over the timeout.
- Undefined: no counter; WAIT lasts indefinitely; timeout tied 0.

Decomposition:
- Package fproc_pkg:
  - state enum (IDLE, WAIT, RESP)
  - response encodings: FPROC_DATA_BADID = 0, FPROC_DATA_TIMEOUT = all ones
  - default widths
- Sub-module meas_latch_bank (N_MEAS):
  - Holds the fresh/bit registers.
  - Exposes fresh vector, stored bits, consume strobe with index, and overrun detection.
  - FSM stays in fproc_meas.

Test Plan:
- meas_valid[3]=1, meas_bit[3]=1 at cycle 10; fproc_en with id=3 at cycle 15 -> fproc_ready at 16, fproc_data=0x00000001, fresh[3] cleared, busy=1 at 16.
- fproc_en with id=5 at cycle 20; meas_valid[5]=1, meas_bit[5]=0 at cycle 30 -> fproc_ready only at 31, data=0; busy=1 for cycles 21..31.
- fproc_en with id=2 in the same cycle as meas_valid[2]=1, bit=1 -> ready next cycle, data=1; fresh[2] stays 0.
- fproc_en with id=9 (N_MEAS=8) -> ready next cycle, data=0, err_bad_id=1 stays set. Second fproc_en during WAIT -> err_overrun=1, no extra fproc_ready.
- Without the macro: id=1 requested, reset pulsed low during WAIT -> all outputs 0 immediately, no ready. With FPROC_TIMEOUT_EN and TIMEOUT_CYCLES=16: id=4, no meas -> ready after the full TIMEOUT_CYCLES wait, data=0xFFFFFFFF, timeout=1.
